// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between decode, muldiv_unit and the accumulator buffer.
// The slave modport is the execute unit; master is the decode/accumulator side.
interface muldiv_unit_if #(
  parameter int WIDTH = 16,
  parameter int REGW  = 4
);
  logic             branch;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [REGW-1:0]  wr_in;
  logic             mem_regin;
  logic             busy;
  logic [WIDTH-1:0] out;
  logic [REGW-1:0]  wr_out;
  logic             write_out;
  logic             mem_regout;
  logic [WIDTH-1:0] hi;
  logic             illegal;

  modport master (
    output branch, start, op, a, b, wr_in, mem_regin,
    input  busy, out, wr_out, write_out, mem_regout, hi, illegal
  );

  modport slave (
    input  branch, start, op, a, b, wr_in, mem_regin,
    output busy, out, wr_out, write_out, mem_regout, hi, illegal
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned shift-add multiplier / restoring divider with a HI register.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV raises a one-cycle illegal pulse.
module muldiv_unit #(
  parameter int WIDTH = 16,
  parameter int REGW  = 4
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);
  localparam int            CW     = $clog2(WIDTH);
  localparam logic [0:0]    S_IDLE = 1'b0;
  localparam logic [0:0]    S_RUN  = 1'b1;
  localparam logic [1:0]    OP_MUL = 2'b00;
  localparam logic [1:0]    OP_DIV = 2'b01;
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);

  logic [0:0]         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [REGW-1:0]    wr_q, wr_d;
  logic               mreg_q, mreg_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [REGW-1:0]    wr_out_q, wr_out_d;
  logic               write_q, write_d;
  logic               mreg_out_q, mreg_out_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               illegal_q, illegal_d;
  logic               accept_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_step_s;
  logic [2*WIDTH-1:0] step_s;

  assign accept_s = (state_q == S_IDLE) && bus.start && !bus.branch;

  // work_q holds {partial product, remaining multiplier}; one multiplier bit retires per step
  always_comb begin
    mul_sum_s  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, (work_q[0] ? b_q : {WIDTH{1'b0}})};
    mul_step_s = {mul_sum_s, work_q[WIDTH-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic               op_q;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_trial_s;
  logic               div_borrow_s;
  logic [2*WIDTH-1:0] div_step_s;

  // work_q holds {remainder, dividend/quotient}; b=0 never borrows, giving 0xFFFF and rem=a
  always_comb begin
    div_shift_s  = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_trial_s  = div_shift_s - {1'b0, b_q};
    div_borrow_s = div_trial_s[WIDTH];
    div_step_s   = {(div_borrow_s ? div_shift_s[WIDTH-1:0] : div_trial_s[WIDTH-1:0]),
                    work_q[WIDTH-2:0], ~div_borrow_s};
    step_s       = op_q ? div_step_s : mul_step_s;
  end

  // Remember which iterative operation is in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= 1'b0;
    end else if (accept_s) begin
      op_q <= (bus.op == OP_DIV);
    end else begin
      op_q <= op_q;
    end
  end
`else
  // Multiply is the only iterative operation in this build
  always_comb step_s = mul_step_s;
`endif

  // Next-state: flush, issue, iterate, complete
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    work_d     = work_q;
    b_d        = b_q;
    wr_d       = wr_q;
    mreg_d     = mreg_q;
    busy_d     = busy_q;
    out_d      = out_q;
    wr_out_d   = {REGW{1'b0}};
    write_d    = 1'b0;
    mreg_out_d = mreg_out_q;
    hi_d       = hi_q;
    illegal_d  = 1'b0;
    if (bus.branch) begin
      state_d    = S_IDLE;
      busy_d     = 1'b0;
      out_d      = {WIDTH{1'b0}};
      mreg_out_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            work_d = {{WIDTH{1'b0}}, bus.a};
            b_d    = bus.b;
            wr_d   = bus.wr_in;
            mreg_d = bus.mem_regin;
            case (bus.op)
              OP_MUL: begin
                state_d = S_RUN;
                count_d = {CW{1'b0}};
                busy_d  = 1'b1;
              end
              OP_DIV: begin
`ifdef MULDIV_DIV_EN
                state_d = S_RUN;
                count_d = {CW{1'b0}};
                busy_d  = 1'b1;
`else
                illegal_d = 1'b1;
`endif
              end
              default: begin
                out_d      = hi_q;
                wr_out_d   = bus.wr_in;
                write_d    = 1'b1;
                mreg_out_d = bus.mem_regin;
              end
            endcase
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RUN: begin
          work_d  = step_s;
          count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
          if (count_q == LAST) begin
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            out_d      = step_s[WIDTH-1:0];
            hi_d       = step_s[2*WIDTH-1:WIDTH];
            wr_out_d   = wr_q;
            write_d    = 1'b1;
            mreg_out_d = mreg_q;
          end else begin
            state_d = S_RUN;
          end
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and registered result port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= {CW{1'b0}};
      work_q     <= {(2*WIDTH){1'b0}};
      b_q        <= {WIDTH{1'b0}};
      wr_q       <= {REGW{1'b0}};
      mreg_q     <= 1'b0;
      busy_q     <= 1'b0;
      out_q      <= {WIDTH{1'b0}};
      wr_out_q   <= {REGW{1'b0}};
      write_q    <= 1'b0;
      mreg_out_q <= 1'b1;
      hi_q       <= {WIDTH{1'b0}};
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      work_q     <= work_d;
      b_q        <= b_d;
      wr_q       <= wr_d;
      mreg_q     <= mreg_d;
      busy_q     <= busy_d;
      out_q      <= out_d;
      wr_out_q   <= wr_out_d;
      write_q    <= write_d;
      mreg_out_q <= mreg_out_d;
      hi_q       <= hi_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.out        = out_q;
  assign bus.wr_out     = wr_out_q;
  assign bus.write_out  = write_q;
  assign bus.mem_regout = mreg_out_q;
  assign bus.hi         = hi_q;
  assign bus.illegal    = illegal_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; DIV vectors run when MULDIV_DIV_EN is defined,
// the illegal-op vector otherwise.
module tb_muldiv_unit;
  logic clk;
  logic rst;
  int   nerr;
  int   nchk;
  int   wcnt;
  int   bcnt;

  muldiv_unit_if #(.WIDTH(16), .REGW(4)) bus ();

  muldiv_unit #(.WIDTH(16), .REGW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_out"},     32'(bus.out),        32'h0000_0000);
    chk({pfx, "_wr"},      32'(bus.wr_out),     32'h0000_0000);
    chk({pfx, "_write"},   32'(bus.write_out),  32'h0000_0000);
    chk({pfx, "_mreg"},    32'(bus.mem_regout), 32'h0000_0001);
    chk({pfx, "_busy"},    32'(bus.busy),       32'h0000_0000);
    chk({pfx, "_hi"},      32'(bus.hi),         32'h0000_0000);
    chk({pfx, "_illegal"}, 32'(bus.illegal),    32'h0000_0000);
  endtask

  initial begin
    nerr = 0;
    nchk = 0;
    rst = 1'b1;
    bus.branch = 1'b0;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a = 16'h0000;
    bus.b = 16'h0000;
    bus.wr_in = 4'h0;
    bus.mem_regin = 1'b0;
    repeat (2) tick();
    chk_reset("rst0");
    rst = 1'b0;

    // MUL 0x1234 * 0x0010
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 16'h1234; bus.b = 16'h0010; bus.wr_in = 4'h3; bus.mem_regin = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("mul1_busy", 32'(bus.busy), 32'h0000_0001);
      chk("mul1_nowr", 32'(bus.write_out), 32'h0000_0000);
      tick();
    end
    chk("mul1_out",   32'(bus.out),        32'h0000_2340);
    chk("mul1_hi",    32'(bus.hi),         32'h0000_0001);
    chk("mul1_wr",    32'(bus.wr_out),     32'h0000_0003);
    chk("mul1_write", 32'(bus.write_out),  32'h0000_0001);
    chk("mul1_mreg",  32'(bus.mem_regout), 32'h0000_0000);
    chk("mul1_idle",  32'(bus.busy),       32'h0000_0000);
    tick();
    chk("mul1_pulse", 32'(bus.write_out),  32'h0000_0000);

    // MUL 0xFFFF * 0xFFFF then MFHI at E17
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.wr_in = 4'h1; bus.mem_regin = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (15) tick();
    chk("mul2_busy15", 32'(bus.busy), 32'h0000_0001);
    tick();
    chk("mul2_out",   32'(bus.out),       32'h0000_0001);
    chk("mul2_hi",    32'(bus.hi),        32'h0000_FFFE);
    chk("mul2_write", 32'(bus.write_out), 32'h0000_0001);
    chk("mul2_idle",  32'(bus.busy),      32'h0000_0000);
    bus.start = 1'b1; bus.op = 2'b10; bus.wr_in = 4'h5; bus.mem_regin = 1'b0;
    tick();
    bus.start = 1'b0;
    chk("mfhi_out",   32'(bus.out),        32'h0000_FFFE);
    chk("mfhi_wr",    32'(bus.wr_out),     32'h0000_0005);
    chk("mfhi_write", 32'(bus.write_out),  32'h0000_0001);
    chk("mfhi_mreg",  32'(bus.mem_regout), 32'h0000_0000);
    chk("mfhi_busy",  32'(bus.busy),       32'h0000_0000);
    tick();
    chk("mfhi_pulse", 32'(bus.write_out),  32'h0000_0000);
    chk("mfhi_wr0",   32'(bus.wr_out),     32'h0000_0000);
    chk("mfhi_hold",  32'(bus.out),        32'h0000_FFFE);

`ifndef MULDIV_DIV_EN
    // DIV with the divider compiled out
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 16'h0009; bus.b = 16'h0003; bus.wr_in = 4'h6;
    tick();
    bus.start = 1'b0;
    chk("ill_pulse", 32'(bus.illegal),   32'h0000_0001);
    chk("ill_write", 32'(bus.write_out), 32'h0000_0000);
    chk("ill_wr",    32'(bus.wr_out),    32'h0000_0000);
    chk("ill_busy",  32'(bus.busy),      32'h0000_0000);
    chk("ill_out",   32'(bus.out),       32'h0000_FFFE);
    chk("ill_hi",    32'(bus.hi),        32'h0000_FFFE);
    tick();
    chk("ill_end",   32'(bus.illegal),   32'h0000_0000);
    chk("ill_busy2", 32'(bus.busy),      32'h0000_0000);
`endif

    // Branch flush at iteration 8 with a competing start
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 16'h0002; bus.b = 16'h0003; bus.wr_in = 4'h4; bus.mem_regin = 1'b0;
    tick();
    bus.start = 1'b0;
    repeat (8) tick();
    chk("br_busy_pre", 32'(bus.busy), 32'h0000_0001);
    bus.branch = 1'b1; bus.start = 1'b1; bus.a = 16'h0005; bus.b = 16'h0005;
    tick();
    bus.branch = 1'b0; bus.start = 1'b0;
    chk("br_busy",  32'(bus.busy),       32'h0000_0000);
    chk("br_write", 32'(bus.write_out),  32'h0000_0000);
    chk("br_mreg",  32'(bus.mem_regout), 32'h0000_0001);
    chk("br_out",   32'(bus.out),        32'h0000_0000);
    chk("br_wr",    32'(bus.wr_out),     32'h0000_0000);
    chk("br_hi",    32'(bus.hi),         32'h0000_FFFE);
    wcnt = 0;
    bcnt = 0;
    repeat (20) begin
      tick();
      if (bus.write_out) wcnt++;
      if (bus.busy) bcnt++;
    end
    chk("br_nowrites", 32'(wcnt), 32'h0000_0000);
    chk("br_noaccept", 32'(bcnt), 32'h0000_0000);

    // start held high throughout busy yields a single completion
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 16'h0003; bus.b = 16'h0005; bus.wr_in = 4'h2; bus.mem_regin = 1'b1;
    tick();
    wcnt = 0;
    repeat (16) begin
      tick();
      if (bus.write_out) wcnt++;
    end
    bus.start = 1'b0;
    chk("hold_out",   32'(bus.out),        32'h0000_000F);
    chk("hold_hi",    32'(bus.hi),         32'h0000_0000);
    chk("hold_wr",    32'(bus.wr_out),     32'h0000_0002);
    chk("hold_mreg",  32'(bus.mem_regout), 32'h0000_0001);
    chk("hold_write", 32'(bus.write_out),  32'h0000_0001);
    repeat (4) begin
      tick();
      if (bus.write_out) wcnt++;
    end
    chk("hold_single", 32'(wcnt), 32'h0000_0001);

`ifdef MULDIV_DIV_EN
    // DIV 100 / 7
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 16'd100; bus.b = 16'd7; bus.wr_in = 4'h8; bus.mem_regin = 1'b0;
    tick();
    bus.start = 1'b0;
    repeat (16) tick();
    chk("div1_out",   32'(bus.out),       32'h0000_000E);
    chk("div1_hi",    32'(bus.hi),        32'h0000_0002);
    chk("div1_write", 32'(bus.write_out), 32'h0000_0001);
    chk("div1_wr",    32'(bus.wr_out),    32'h0000_0008);
    tick();
    // DIV by zero keeps the normal latency
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 16'h0055; bus.b = 16'h0000; bus.wr_in = 4'h9;
    tick();
    bus.start = 1'b0;
    repeat (15) tick();
    chk("div0_busy15", 32'(bus.busy),      32'h0000_0001);
    chk("div0_nowr",   32'(bus.write_out), 32'h0000_0000);
    tick();
    chk("div0_out",   32'(bus.out),       32'h0000_FFFF);
    chk("div0_hi",    32'(bus.hi),        32'h0000_0055);
    chk("div0_write", 32'(bus.write_out), 32'h0000_0001);
    chk("div0_idle",  32'(bus.busy),      32'h0000_0000);
    tick();
`endif

    // Reset in the middle of an iterative op
`ifdef MULDIV_DIV_EN
    bus.op = 2'b01;
`else
    bus.op = 2'b00;
`endif
    bus.start = 1'b1; bus.a = 16'd100; bus.b = 16'd7; bus.wr_in = 4'h3; bus.mem_regin = 1'b0;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    chk("rstmid_busy", 32'(bus.busy), 32'h0000_0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("rstmid");
    wcnt = 0;
    repeat (14) begin
      tick();
      if (bus.write_out) wcnt++;
    end
    chk("rstmid_nowr", 32'(wcnt), 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative unsigned multiply/divide execute unit for the 16-bit pipeline.
- Accepts one operation from decode; computes it over several cycles while stalling decode via `busy`.
- Presents the result on a registered port bundle that connects straight into the accumulator buffer register's `in`, `wr_in`, `write_in` and `mem_regin` inputs.
- Holds an architectural HI register: MUL writes the upper product half, DIV writes the remainder, MFHI reads it back.

## Interface
Parameters:
- `WIDTH`, 16: operand/result width (RTL and test plan fixed at 16).
- `REGW`, 4: destination register address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `branch` in 1: pipeline flush, same meaning as the accumulator flush.
- `start` in 1: issue request; accepted only when `busy`=0 and `branch`=0.
- `op` in 2: 00 MUL, 01 DIV, 10 MFHI, 11 reserved (treated as MFHI).
- `a`, `b` in 16: operands. DIV is a/b.
- `wr_in` in 4: destination register.
- `mem_regin` in 1: writeback-select bit, carried alongside the result.
- `busy` out 1: registered stall to decode.
- `out` out 16: result to the accumulator.
- `wr_out` out 4: destination to the accumulator.
- `write_out` out 1: write-enable pulse to the accumulator.
- `mem_regout` out 1: writeback-select to the accumulator.
- `hi` out 16: HI register contents.
- `illegal` out 1: one-cycle pulse for a disabled op (see Configuration).

## Operation
- States: IDLE, RUN.
- Acceptance: at an edge with state IDLE, `start`=1 and `branch`=0:
  - latch `op`, `a`, `b`, `wr_in`, `mem_regin`.
  - MUL/DIV: state→RUN, count→0, `busy`→1.
  - MFHI: no RUN; next edge drives `out`=`hi`, `write_out`=1.
- MUL: shift-add, one multiplier bit per cycle, 32-bit product.
  - Completion: `out`=product[15:0], `hi`=product[31:16].
- DIV: restoring divide, one quotient bit per cycle.
  - Completion: `out`=quotient, `hi`=remainder.
  - b=0: `out`=0xFFFF, `hi`=a; same latency, no special state.
- Completion edge (count=15 in RUN):
  - state→IDLE, `busy`→0.
  - `write_out`=1, `wr_out`=latched wr, `mem_regout`=latched bit.
- Non-completion edges: `write_out`=0, `wr_out`=0; `out` holds its last value.
- All arithmetic is unsigned; no overflow flags.
- `branch`=1 at any edge (priority below `rst`):
  - state→IDLE, `busy`=0, `out`=0, `wr_out`=0, `write_out`=0, `mem_regout`=1.
  - In-flight op discarded, `hi` unchanged, `start` that cycle ignored.
- `rst`=1: the same output values as `branch`, plus `hi`=0, `illegal`=0.
- `start` while `busy`=1: ignored, no queuing; decode must hold the instruction.

## Timing
- Reset values: `out`=0x0000, `wr_out`=0, `write_out`=0, `mem_regout`=1, `busy`=0, `hi`=0x0000, `illegal`=0.
- MFHI: accepted at edge E0; `write_out`=1 in the cycle after E0; `busy` never asserts. MFHI issued the cycle after a MUL/DIV completion reads the new `hi`.
- MUL/DIV: accepted at E0.
  - `busy`=1 for the 16 cycles following E0.
  - E1–E16 perform iterations 0–15.
  - The E16 result appears in the cycle after E16 with `write_out`=1 for exactly one cycle.
- Back-to-back issue: `start` may be accepted at E17 (busy low after E16). Throughput is one MUL/DIV per 17 cycles.
- `hi` updates on the same edge that raises `write_out`.
- `busy` is registered only; there is no combinational `start`→`busy` path.

## Configuration
- `MULDIV_DIV_EN` defined:
  - Divider datapath compiled in; DIV behaves as above.
- `MULDIV_DIV_EN` undefined:
  - No divider logic.
  - DIV is accepted as a 1-cycle op: next cycle `illegal`=1, `write_out`=0, `wr_out`=0, `out` and `hi` unchanged, `busy` stays 0.
  - With the macro defined, `illegal` is tied to 0.

## Test plan
- Reset then MUL a=0x1234 b=0x0010 wr=3 → `busy` high 16 cycles; then `out`=0x2340, `hi`=0x0001, `wr_out`=3, `write_out`=1 for one cycle.
- MUL 0xFFFF×0xFFFF, then MFHI wr=5 issued at E17 → `out`=0x0001 with write; next cycle `out`=0xFFFE, `wr_out`=5.
- DIV 100/7 → `out`=0x000E, `hi`=0x0002. DIV 0x0055/0 → `out`=0xFFFF, `hi`=0x0055, same 16-cycle latency.
- MUL in flight, `branch`=1 at iteration 8 with `start`=1 → no `write_out`, `busy`=0 next cycle, `mem_regout`=1, `hi` unchanged, new op not accepted.
- `rst` mid-DIV → all outputs at reset values next cycle, `hi`=0. `start` held during `busy` → ignored, single completion only.
- Build without `MULDIV_DIV_EN`, DIV 9/3 → `illegal` one-cycle pulse, `write_out`=0, `busy` stays 0.
